cd_scsi_phase_ctrl: RTL and testbench
=====================================

Name: cd_scsi_phase_ctrl

Overview:
Clocked SCSI bus-phase sequencer for the PCE CD-ROM interface.
- Owns the CDC_STAT bus-status bits (BSY/REQ/MSG/CD/IO) and runs the REQ/ACK byte handshake with the host through the full transaction: command, data-in, status, message-in, back to bus free.
- Command bytes go out to the drive core.
- Drive read data is buffered in a parametrised FIFO before the host collects it.

Parameters:
- DATA_W, 8, width of bus data and command bytes.
- FIFO_DEPTH, 8, data-in buffer depth in bytes; must be a power of two, ≥2.
- CMD_LEN_OTHER, 10, command length for opcode groups 3–7.
- MSG_BYTE, 8'h00, byte sent in MESSAGE_IN (COMMAND COMPLETE).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  host selection request.
- ack  in  1  host ACK.
- host_data  in  DATA_W  host-to-drive byte, sampled on the ACK edge in COMMAND.
- bus_data  out  DATA_W  drive-to-host byte; valid while REQ=1 in DATA_IN, STATUS and MESSAGE_IN.
- cd_status  out  8  {BSY,REQ,MSG,CD,IO,3'b000}.
- phase  out  7  one-hot phase code: BUS_FREE=0, COMMAND=01, DATA_IN=02, DATA_OUT=04, STATUS=08, MESSAGE_IN=10, MESSAGE_OUT=20.
- cmd_wr  out  1  one-cycle strobe per accepted command byte.
- cmd_wdata  out  DATA_W  command byte accompanying cmd_wr.
- cmd_done  out  1  one-cycle strobe after the final command byte.
- dat_valid  in  1  drive data byte valid.
- dat_data  in  DATA_W  drive data byte.
- dat_last  in  1  marks the final data byte.
- dat_ready  out  1  FIFO can accept a byte (= !full).
- status_valid  in  1  drive status available; one-cycle pulse.
- status_code  in  DATA_W  SCSI status byte.

Behaviour:
- All outputs registered.
- On reset: state BUS_FREE, cd_status=8'h00, phase=8'h00, bus_data=0, cmd_wr/cmd_done=0, FIFO flushed (dat_ready=1), byte counter=0, status latch cleared.
- Reset mid-transaction aborts immediately with no strobes.

States and cd_status (REQ=0 / REQ=1):
- BUS_FREE: 00. No REQ.
- COMMAND: 90 / D0.
- EXEC: 80. BSY only, no REQ; phase holds COMMAND.
- DATA_IN: 88 / C8.
- STATUS: 98 / D8.
- MESSAGE_IN: B8 / F8.
- DATA_OUT and MESSAGE_OUT codes are reserved and never entered.

REQ/ACK handshake (all transfer phases):
- REQ rises only when ack is sampled low and a byte is available (data phases) or a byte is wanted (COMMAND).
- A transfer occurs on the edge where REQ=1 and ack=1.
- REQ is low the following cycle and stays low until ack is sampled low.
- bus_data is stable while REQ=1.
- ack high outside REQ is ignored.

Transitions:
- BUS_FREE → COMMAND: sel=1 sampled. The next cycle shows cd_status=D0. sel is ignored in any other state.
- COMMAND byte count (from the first byte, opcode[7:5]):
  - group 0: 6 bytes.
  - groups 1–2: 10 bytes.
  - other groups: CMD_LEN_OTHER bytes.
- Each accepted byte produces cmd_wr=1 with cmd_wdata=host_data one cycle after the ACK edge.
- cmd_done pulses together with the final cmd_wr; the state then goes to EXEC.
- EXEC:
  - A dat_valid accept moves to DATA_IN.
  - status_valid with an empty FIFO moves directly to STATUS (zero-length transfer).
  - If dat_valid and status_valid coincide, the byte is accepted and status is latched; DATA_IN is taken.
- DATA_IN:
  - The FIFO pushes on dat_valid & dat_ready and pops on each ACK transfer.
  - A push and a pop in the same cycle keeps the count unchanged.
  - Pushes while full are prevented by dat_ready=0.
  - dat_last is latched.
  - status_valid arriving during DATA_IN is latched and held.
  - Exit to STATUS when dat_last has been seen, the FIFO is empty after the last pop, and status is latched.
  - If status is not yet latched, stay in DATA_IN with REQ=0 until status_valid.
- STATUS: bus_data=latched status_code; after one transfer → MESSAGE_IN.
- MESSAGE_IN: bus_data=MSG_BYTE; after one transfer → BUS_FREE (cd_status=00), clearing the counter, latches and dat_last.
- Clearing cd_status bits must never set other bits. Each phase's code is an exact assignment, not an OR onto the prior value.

Test Plan:
- Reset with any prior state → cd_status=00, phase=00, dat_ready=1. Assert reset mid-DATA_IN with 3 bytes buffered → next cycle cd_status=00, FIFO empty.
- sel pulse → cd_status=D0. Send 6 bytes 08 00 00 10 00 01 via ACK → six cmd_wr strobes with matching data, cmd_done on the 6th, then cd_status=80. Opcode 28 → 10 bytes required.
- Drive pushes 12 bytes with FIFO_DEPTH=8 and slow ACK → dat_ready=0 while 8 bytes are held. Host reads all 12 in order. cd_status toggles C8/88 per byte.
- status_valid(00) during DATA_IN with bytes pending → STATUS reached only after the last byte is ACKed. D8 presents 00, then F8 presents MSG_BYTE 00, then cd_status=00.
- Zero-length: status_valid(02) in EXEC → STATUS directly. bus_data=02, no DATA_IN phase.
- ACK held high across bytes → only one transfer. REQ stays low until ack returns low. sel during DATA_IN is ignored.

Source files
------------

// File: rtl/cd_scsi_phase_ctrl_if.sv
// cd_scsi_phase_ctrl_if: host SCSI bus, command stream and drive data/status signals.
interface cd_scsi_phase_ctrl_if #(parameter int DATA_W = 8);
  logic              sel;
  logic              ack;
  logic [DATA_W-1:0] host_data;
  logic [DATA_W-1:0] bus_data;
  logic [7:0]        cd_status;
  logic [6:0]        phase;
  logic              cmd_wr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_done;
  logic              dat_valid;
  logic [DATA_W-1:0] dat_data;
  logic              dat_last;
  logic              dat_ready;
  logic              status_valid;
  logic [DATA_W-1:0] status_code;
  modport slave (
    input  sel, ack, host_data, dat_valid, dat_data, dat_last, status_valid, status_code,
    output bus_data, cd_status, phase, cmd_wr, cmd_wdata, cmd_done, dat_ready
  );
  modport master (
    output sel, ack, host_data, dat_valid, dat_data, dat_last, status_valid, status_code,
    input  bus_data, cd_status, phase, cmd_wr, cmd_wdata, cmd_done, dat_ready
  );
endinterface

// File: rtl/cd_scsi_phase_ctrl.sv
// cd_scsi_phase_ctrl: SCSI bus-phase sequencer with REQ/ACK handshake and data-in FIFO.
module cd_scsi_phase_ctrl #(
  parameter int                DATA_W        = 8,
  parameter int                FIFO_DEPTH    = 8,
  parameter int                CMD_LEN_OTHER = 10,
  parameter logic [DATA_W-1:0] MSG_BYTE      = '0
) (
  input logic                 clk,
  input logic                 reset,
  cd_scsi_phase_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {S_FREE, S_CMD, S_EXEC, S_DIN, S_STAT, S_MSG} state_e;
  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [7:0]        cnt_q, cnt_d, len_q, len_d, first_len;
  logic [DATA_W-1:0] bus_q, bus_d, wdata_q, wdata_d, code_q, code_d;
  logic              wr_q, wr_d, done_q, done_d, stat_q, stat_d, last_q, last_d;
  logic [7:0]        cd_q, cd_d;
  logic [6:0]        phase_q, phase_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wp_q, rp_q;
  logic [AW:0]       fcnt_q, fcnt_d;
  logic              ready_q, push, pop, xfer, busy;
  assign busy      = state_q == S_EXEC || state_q == S_DIN;
  assign push      = bus.dat_valid && ready_q && busy;
  assign xfer      = req_q && bus.ack;
  assign pop       = xfer && state_q == S_DIN;
  assign fcnt_d    = fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign first_len = bus.host_data[DATA_W-1:DATA_W-3] == 3'd0 ? 8'd6 :
                     bus.host_data[DATA_W-1:DATA_W-3] < 3'd3  ? 8'd10 : CMD_LEN_OTHER[7:0];
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    bus_d   = bus_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    stat_d  = stat_q || (bus.status_valid && busy);
    code_d  = (bus.status_valid && busy) ? bus.status_code : code_q;
    last_d  = last_q || (push && bus.dat_last);
    case (state_q)
      S_FREE: if (bus.sel) begin
        state_d = S_CMD;
        req_d   = !bus.ack;
        cnt_d   = '0;
      end
      S_CMD: if (xfer) begin
        req_d   = 1'b0;
        wr_d    = 1'b1;
        wdata_d = bus.host_data;
        cnt_d   = cnt_q + 8'd1;
        len_d   = cnt_q == 8'd0 ? first_len : len_q;
        if (cnt_q + 8'd1 == len_d) begin
          done_d  = 1'b1;
          state_d = S_EXEC;
        end
      end else req_d = req_q || !bus.ack;
      S_EXEC: if (push) state_d = S_DIN;
      else if (bus.status_valid && fcnt_q == '0) begin
        state_d = S_STAT;
        bus_d   = bus.status_code;
      end
      S_DIN: if (xfer) req_d = 1'b0;
      else if (!req_q) begin
        req_d = !bus.ack && fcnt_q != '0;
        bus_d = mem_q[rp_q];
        // leave only once the drive is finished, the host has drained every byte and status is known
        if (fcnt_q == '0 && last_q && stat_q) begin
          state_d = S_STAT;
          bus_d   = code_q;
        end
      end
      S_STAT: if (xfer) begin
        req_d   = 1'b0;
        state_d = S_MSG;
        bus_d   = MSG_BYTE;
      end else req_d = req_q || !bus.ack;
      S_MSG: if (xfer) begin
        req_d   = 1'b0;
        state_d = S_FREE;
        cnt_d   = '0;
        stat_d  = 1'b0;
        last_d  = 1'b0;
      end else req_d = req_q || !bus.ack;
      default: state_d = S_FREE;
    endcase
    cd_d = (state_d == S_FREE ? 8'h00 : state_d == S_CMD ? 8'h90 : state_d == S_EXEC ? 8'h80 :
            state_d == S_DIN ? 8'h88 : state_d == S_STAT ? 8'h98 : 8'hB8) | {1'b0, req_d, 6'b0};
    phase_d = state_d == S_FREE ? 7'h00 : (state_d == S_CMD || state_d == S_EXEC) ? 7'h01 :
              state_d == S_DIN ? 7'h02 : state_d == S_STAT ? 7'h08 : 7'h10;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FREE;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      bus_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      stat_q  <= 1'b0;
      code_q  <= '0;
      last_q  <= 1'b0;
      cd_q    <= '0;
      phase_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      fcnt_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      bus_q   <= bus_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      stat_q  <= stat_d;
      code_q  <= code_d;
      last_q  <= last_d;
      cd_q    <= cd_d;
      phase_q <= phase_d;
      wp_q    <= wp_q + AW'(push);
      rp_q    <= rp_q + AW'(pop);
      fcnt_q  <= fcnt_d;
      ready_q <= fcnt_d != (AW+1)'(FIFO_DEPTH);
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= bus.dat_data;
  assign bus.bus_data  = bus_q;
  assign bus.cd_status = cd_q;
  assign bus.phase     = phase_q;
  assign bus.cmd_wr    = wr_q;
  assign bus.cmd_wdata = wdata_q;
  assign bus.cmd_done  = done_q;
  assign bus.dat_ready = ready_q;
endmodule

// File: tb/tb_cd_scsi_phase_ctrl.sv
// tb_cd_scsi_phase_ctrl: directed checks of the phase sequencer against hand-derived bus codes.
module tb_cd_scsi_phase_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  cd_scsi_phase_ctrl_if #(.DATA_W(8)) bus ();
  cd_scsi_phase_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.cd_status[6] !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
    end
    chk({tag, "_req"}, 32'(bus.cd_status[6]), 1);
  endtask
  task automatic cmd_byte(input logic [7:0] b, input logic done);
    wait_req("cmd");
    bus.host_data = b;
    bus.ack = 1'b1;
    cyc(1);
    chk("cmd_wr", 32'(bus.cmd_wr), 1);
    chk("cmd_wdata", 32'(bus.cmd_wdata), 32'(b));
    chk("cmd_done", 32'(bus.cmd_done), 32'(done));
    bus.ack = 1'b0;
    cyc(1);
  endtask
  task automatic rd_byte(input string tag, input logic [7:0] b, input logic [7:0] st, input logic [7:0] after);
    wait_req(tag);
    chk({tag, "_st"}, 32'(bus.cd_status), 32'(st));
    chk({tag, "_data"}, 32'(bus.bus_data), 32'(b));
    bus.ack = 1'b1;
    cyc(1);
    chk({tag, "_after"}, 32'(bus.cd_status), 32'(after));
    bus.ack = 1'b0;
    cyc(1);
  endtask
  task automatic push(input logic [7:0] d, input logic last);
    bus.dat_valid = 1'b1;
    bus.dat_data = d;
    bus.dat_last = last;
    cyc(1);
    bus.dat_valid = 1'b0;
    bus.dat_last = 1'b0;
  endtask
  task automatic start_cmd6();
    bus.sel = 1'b1;
    cyc(1);
    bus.sel = 1'b0;
    for (int i = 0; i < 6; i++) cmd_byte(8'h00, i == 5);
  endtask
  initial begin
    reset = 1'b1;
    bus.sel = 0; bus.ack = 0; bus.host_data = 0; bus.dat_valid = 0; bus.dat_data = 0;
    bus.dat_last = 0; bus.status_valid = 0; bus.status_code = 0;
    cyc(3);
    chk("rst_cd", 32'(bus.cd_status), 0);
    chk("rst_phase", 32'(bus.phase), 0);
    chk("rst_ready", 32'(bus.dat_ready), 1);
    chk("rst_bus", 32'(bus.bus_data), 0);
    chk("rst_wr", 32'(bus.cmd_wr), 0);
    reset = 1'b0;
    bus.ack = 1'b1;
    cyc(2);
    chk("idle_ack_ignored", 32'(bus.cd_status), 0);
    bus.ack = 1'b0;
    bus.sel = 1'b1;
    cyc(1);
    bus.sel = 1'b0;
    chk("sel_cd", 32'(bus.cd_status), 32'h D0);
    chk("sel_phase", 32'(bus.phase), 1);
    cmd_byte(8'h08, 0); cmd_byte(8'h00, 0); cmd_byte(8'h00, 0);
    cmd_byte(8'h10, 0); cmd_byte(8'h00, 0); cmd_byte(8'h01, 1);
    chk("exec_cd", 32'(bus.cd_status), 32'h80);
    chk("exec_phase", 32'(bus.phase), 1);
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i), 1'b0);
    chk("full_ready", 32'(bus.dat_ready), 0);
    chk("din_cd", 32'(bus.cd_status), 32'hC8);
    chk("din_phase", 32'(bus.phase), 2);
    push(8'hEE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd_byte("din", 8'hA0 + 8'(i), 8'hC8, 8'h88);
      chk("ready_after_pop", 32'(bus.dat_ready), 1);
      bus.status_valid = (i == 1);
      bus.sel = (i == 1);
      push(8'hA8 + 8'(i), i == 3);
      bus.status_valid = 1'b0;
      bus.sel = 1'b0;
    end
    chk("sel_ignored", 32'(bus.phase), 2);
    for (int i = 4; i < 12; i++) begin
      if (i == 11) chk("not_yet_status", 32'(bus.phase), 2);
      rd_byte("din", 8'hA0 + 8'(i), 8'hC8, 8'h88);
    end
    rd_byte("stat", 8'h00, 8'hD8, 8'hB8);
    rd_byte("msg", 8'h00, 8'hF8, 8'h00);
    chk("free_phase", 32'(bus.phase), 0);
    bus.sel = 1'b1;
    cyc(1);
    bus.sel = 1'b0;
    wait_req("held");
    bus.host_data = 8'h28;
    bus.ack = 1'b1;
    cyc(1);
    chk("held_wr", 32'(bus.cmd_wr), 1);
    chk("held_data", 32'(bus.cmd_wdata), 32'h28);
    cyc(1);
    chk("held_wr_once", 32'(bus.cmd_wr), 0);
    chk("held_req_low", 32'(bus.cd_status), 32'h90);
    cyc(1);
    chk("held_req_low2", 32'(bus.cd_status[6]), 0);
    bus.ack = 1'b0;
    cyc(1);
    chk("held_req_back", 32'(bus.cd_status), 32'hD0);
    for (int i = 1; i < 10; i++) cmd_byte(8'(i), i == 9);
    chk("g1_exec", 32'(bus.cd_status), 32'h80);
    bus.status_valid = 1'b1;
    bus.status_code = 8'h02;
    cyc(1);
    bus.status_valid = 1'b0;
    chk("zlen_phase", 32'(bus.phase), 8);
    chk("zlen_cd", 32'(bus.cd_status), 32'h98);
    rd_byte("zstat", 8'h02, 8'hD8, 8'hB8);
    rd_byte("zmsg", 8'h00, 8'hF8, 8'h00);
    start_cmd6();
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0);
    cyc(2);
    chk("mid_phase", 32'(bus.phase), 2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("abort_cd", 32'(bus.cd_status), 0);
    chk("abort_phase", 32'(bus.phase), 0);
    chk("abort_ready", 32'(bus.dat_ready), 1);
    chk("abort_wr", 32'(bus.cmd_wr), 0);
    chk("abort_done", 32'(bus.cmd_done), 0);
    start_cmd6();
    bus.status_valid = 1'b1;
    bus.status_code = 8'h05;
    cyc(1);
    bus.status_valid = 1'b0;
    chk("flushed_phase", 32'(bus.phase), 8);
    rd_byte("fstat", 8'h05, 8'hD8, 8'hB8);
    rd_byte("fmsg", 8'h00, 8'hF8, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
